// File: rtl/ntt_bitrev_reorder_if.sv
// Stream bundle for ntt_bitrev_reorder: the bit-reversed input side
// and the natural-order output side, each with its own valid/ready.
interface ntt_bitrev_reorder_if #(
  parameter int data_width = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [data_width-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/ntt_bitrev_reorder.sv
// Ping-pong frame buffer turning SDF bit-reversed output into natural order.
// Define BITREV_REORDER_EN for NTT mode; otherwise a two-frame FIFO.
module ntt_bitrev_reorder #(
  parameter int data_width = 64,
  parameter int addr_width = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ntt_bitrev_reorder_if.slave      bus,
  output logic                     frame_done_tick
);
  localparam int n = 1 << addr_width;
  localparam logic [addr_width-1:0] last_idx = addr_width'(n - 1);

  logic [data_width-1:0] bank [2][n];
  logic [1:0]            full;
  logic [1:0]            full_nxt;
  logic                  wr_sel;
  logic                  rd_sel;
  logic [addr_width-1:0] wr_cnt;
  logic [addr_width-1:0] rd_cnt;
  logic [addr_width-1:0] rd_addr;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  wr_last;
  logic                  rd_last;

`ifdef BITREV_REORDER_EN
  function automatic logic [addr_width-1:0] bitrev(
    input logic [addr_width-1:0] a
  );
    logic [addr_width-1:0] r;
    for (int i = 0; i < addr_width; i++) begin
      r[i] = a[addr_width-1-i];
    end
    return r;
  endfunction

  assign rd_addr = bitrev(rd_cnt);
`else
  assign rd_addr = rd_cnt;
`endif

  assign bus.in_ready  = !full[wr_sel];
  assign bus.out_valid = full[rd_sel];
  assign bus.out_data  = bank[rd_sel][rd_addr];
  assign bus.out_last  = full[rd_sel] && rd_last;

  assign wr_fire = bus.in_valid && !full[wr_sel];
  assign rd_fire = bus.out_ready && full[rd_sel];
  assign wr_last = wr_cnt == last_idx;
  assign rd_last = rd_cnt == last_idx;

  // Write and read always target different banks, so both edits can land.
  always_comb begin
    full_nxt = full;
    if (wr_fire && wr_last) full_nxt[wr_sel] = 1'b1;
    if (rd_fire && rd_last) full_nxt[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full            <= '0;
      wr_sel          <= 1'b0;
      rd_sel          <= 1'b0;
      wr_cnt          <= '0;
      rd_cnt          <= '0;
      frame_done_tick <= 1'b0;
    end else begin
      full            <= full_nxt;
      frame_done_tick <= rd_fire && rd_last;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + addr_width'(1);
        if (wr_last) wr_sel <= !wr_sel;
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + addr_width'(1);
        if (rd_last) rd_sel <= !rd_sel;
      end
    end
  end

  // Storage is deliberately not reset; the full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_fire) bank[wr_sel][wr_cnt] <= bus.in_data;
  end
endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// Randomized bench for ntt_bitrev_reorder against a frame-queue model.
// Follows BITREV_REORDER_EN the same way the design does.
module tb_ntt_bitrev_reorder;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_done_tick;

  ntt_bitrev_reorder_if #(.data_width(64)) bus ();

  ntt_bitrev_reorder #(
    .data_width(64),
    .addr_width(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .frame_done_tick(frame_done_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [63:0] cur[N];
  int nfull, rd_idx, wcnt;
  logic tick_m;

  logic o_valid, o_ready, o_last, o_tick;
  logic e_valid, e_ready, e_last, e_tick;
  logic [63:0] o_data, e_data;

  logic [63:0] ref_br[N] = '{64'h10, 64'h14, 64'h12, 64'h16,
                             64'h11, 64'h15, 64'h13, 64'h17};
  logic [63:0] got[$];

  function automatic int perm(input int i);
    int r, a;
    r = 0;
    a = i;
`ifdef BITREV_REORDER_EN
    for (int b = 0; b < 3; b++) begin
      r = r * 2 + a % 2;
      a = a / 2;
    end
`else
    r = a;
`endif
    return r;
  endfunction

  function automatic logic [63:0] ref_word(input int i, input int base);
`ifdef BITREV_REORDER_EN
    return ref_br[i] - 64'h10 + 64'(base);
`else
    return 64'(base + i);
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    nfull = 0;
    rd_idx = 0;
    wcnt = 0;
    tick_m = 1'b0;
  endtask

  // Drives one cycle, records DUT and model views, then advances the model.
  task automatic drive_cycle(input logic v, input logic [63:0] d,
                             input logic r);
    logic acc, rd;
    bus.in_valid = v;
    bus.in_data = d;
    bus.out_ready = r;
    #1;
    o_valid = bus.out_valid;
    o_ready = bus.in_ready;
    o_data = bus.out_data;
    o_last = bus.out_last;
    o_tick = frame_done_tick;
    e_valid = nfull > 0;
    e_ready = nfull < 2;
    e_data = e_valid ? exp_q[0] : 64'h0;
    e_last = e_valid && rd_idx == N - 1;
    e_tick = tick_m;
    tick_m = 1'b0;
    acc = v && e_ready;
    rd = e_valid && r;
    if (rd) begin
      void'(exp_q.pop_front());
      rd_idx++;
      if (rd_idx == N) begin
        rd_idx = 0;
        nfull--;
        tick_m = 1'b1;
      end
    end
    if (acc) begin
      cur[wcnt] = d;
      wcnt++;
      if (wcnt == N) begin
        for (int i = 0; i < N; i++) exp_q.push_back(cur[perm(i)]);
        nfull++;
        wcnt = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out_last !== 1'b0 || frame_done_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset: ready=%b valid=%b last=%b tick=%b want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_last, frame_done_tick);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_frame();
    int first_v, tick_c;
    first_v = -1;
    tick_c = -1;
    got.delete();
    for (int k = 0; k < 20; k++) begin
      drive_cycle(k < N, 64'(16 + k), 1'b1);
      if (o_valid && first_v < 0) first_v = k;
      if (o_tick && tick_c < 0) tick_c = k;
      if (o_valid) got.push_back(o_data);
      checks++;
      if (o_valid !== e_valid || o_ready !== e_ready || o_tick !== e_tick) begin
        failures++;
        $display("FAIL frame flags c%0d: v=%b r=%b t=%b want %b %b %b",
                 k, o_valid, o_ready, o_tick, e_valid, e_ready, e_tick);
      end
      if (e_valid) begin
        checks++;
        if (o_data !== e_data || o_last !== e_last) begin
          failures++;
          $display("FAIL frame data c%0d: %h last=%b want %h last=%b",
                   k, o_data, o_last, e_data, e_last);
        end
      end
    end
    checks++;
    if (first_v != N || tick_c != 2 * N) begin
      failures++;
      $display("FAIL frame timing: valid@%0d tick@%0d want %0d %0d",
               first_v, tick_c, N, 2 * N);
    end
    checks++;
    if (got.size() != N) begin
      failures++;
      $display("FAIL frame count: %0d want %0d", got.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (got[i] !== ref_word(i, 16)) begin
          failures++;
          $display("FAIL frame order w%0d: %h want %h",
                   i, got[i], ref_word(i, 16));
        end
      end
    end
  endtask

  task automatic test_stream();
    int first_v, last_v, nv;
    first_v = -1;
    last_v = -1;
    nv = 0;
    for (int k = 0; k < 3 * N + 12; k++) begin
      drive_cycle(k < 3 * N, {$urandom, $urandom}, 1'b1);
      if (o_valid) begin
        if (first_v < 0) first_v = k;
        last_v = k;
        nv++;
      end
      checks++;
      if (o_valid !== e_valid || (k < 3 * N && o_ready !== 1'b1) ||
          o_tick !== e_tick) begin
        failures++;
        $display("FAIL stream flags c%0d: v=%b r=%b t=%b want %b 1 %b",
                 k, o_valid, o_ready, o_tick, e_valid, e_tick);
      end
      if (e_valid) begin
        checks++;
        if (o_data !== e_data || o_last !== e_last) begin
          failures++;
          $display("FAIL stream data c%0d: %h want %h", k, o_data, e_data);
        end
      end
    end
    checks++;
    if (nv != 3 * N || last_v - first_v != 3 * N - 1) begin
      failures++;
      $display("FAIL stream contiguity: %0d words over %0d..%0d want %0d",
               nv, first_v, last_v, 3 * N);
    end
  endtask

  task automatic test_back_to_back();
    int nacc, back;
    nacc = 0;
    back = -1;
    for (int k = 0; k < 2 * N + 4; k++) begin
      drive_cycle(1'b1, {$urandom, $urandom}, 1'b0);
      if (o_ready) nacc++;
    end
    checks++;
    if (nacc != 2 * N || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL backpressure: accepted %0d ready=%b want %0d 0",
               nacc, o_ready, 2 * N);
    end
    for (int k = 0; k < 3 * N; k++) begin
      drive_cycle(1'b0, 64'h0, 1'b1);
      if (o_ready && back < 0) back = k;
      checks++;
      if (o_valid !== e_valid || o_ready !== e_ready || o_tick !== e_tick) begin
        failures++;
        $display("FAIL drain flags c%0d: v=%b r=%b t=%b want %b %b %b",
                 k, o_valid, o_ready, o_tick, e_valid, e_ready, e_tick);
      end
      if (e_valid) begin
        checks++;
        if (o_data !== e_data || o_last !== e_last) begin
          failures++;
          $display("FAIL drain data c%0d: %h want %h", k, o_data, e_data);
        end
      end
    end
    checks++;
    if (back != N) begin
      failures++;
      $display("FAIL ready return: cycle %0d want %0d", back, N);
    end
  endtask

  task automatic test_stall();
    logic p_stall;
    logic p_last;
    logic [63:0] p_data;
    int sent;
    p_stall = 1'b0;
    p_last = 1'b0;
    p_data = '0;
    sent = 0;
    for (int k = 0; k < 100; k++) begin
      logic v, r;
      v = sent < 2 * N && $urandom_range(3) != 0;
      r = (k % 4 < 2) ? k[0] == 1'b0 : $urandom_range(1) == 1;
      if (v && e_ready_now()) sent++;
      drive_cycle(v, {$urandom, $urandom}, r);
      checks++;
      if (o_valid !== e_valid || o_ready !== e_ready || o_tick !== e_tick) begin
        failures++;
        $display("FAIL stall flags c%0d: v=%b r=%b t=%b want %b %b %b",
                 k, o_valid, o_ready, o_tick, e_valid, e_ready, e_tick);
      end
      if (e_valid) begin
        checks++;
        if (o_data !== e_data || o_last !== e_last) begin
          failures++;
          $display("FAIL stall data c%0d: %h want %h", k, o_data, e_data);
        end
      end
      if (p_stall) begin
        checks++;
        if (o_data !== p_data || o_last !== p_last) begin
          failures++;
          $display("FAIL stall hold c%0d: %h want %h", k, o_data, p_data);
        end
      end
      p_stall = o_valid && !r;
      p_data = o_data;
      p_last = o_last;
    end
    checks++;
    if (nfull != 0 || wcnt != 0) begin
      failures++;
      $display("FAIL stall leftover: frames=%0d partial=%0d want 0 0",
               nfull, wcnt);
    end
  endtask

  function automatic logic e_ready_now();
    return nfull < 2;
  endfunction

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) drive_cycle(1'b1, 64'(48 + k), 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset: ready=%b valid=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    got.delete();
    for (int k = 0; k < 20; k++) begin
      drive_cycle(k < N, 64'(32 + k), 1'b1);
      if (o_valid) got.push_back(o_data);
      checks++;
      if (o_valid !== e_valid || o_last !== e_last || o_tick !== e_tick) begin
        failures++;
        $display("FAIL midreset flags c%0d: v=%b l=%b t=%b want %b %b %b",
                 k, o_valid, o_last, o_tick, e_valid, e_last, e_tick);
      end
    end
    checks++;
    if (got.size() != N) begin
      failures++;
      $display("FAIL midreset count: %0d want %0d", got.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (got[i] !== ref_word(i, 32)) begin
          failures++;
          $display("FAIL midreset order w%0d: %h want %h",
                   i, got[i], ref_word(i, 32));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_frame();
    test_stream();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ntt_bitrev_reorder.md
# ntt_bitrev_reorder

Ping-pong reorder buffer placed directly downstream of `sdf_top`. The SDF NTT pipeline emits each polynomial of n = 2^addr_width coefficients in bit-reversed index order. This block collects one full frame and replays it in natural index order, with valid/ready handshakes on both sides. Two banks let frame k+1 be written while frame k drains, so steady-state throughput is one coefficient per cycle.

## Interface
- `data_width`, 64, coefficient word width; data is not interpreted, modulo arithmetic is upstream.
- `addr_width`, 3, log2 of frame length; n = 2^addr_width, must be ≥ 1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` holds a coefficient (SDF output stream).
- `in_data`  in  data_width  coefficient, arriving in bit-reversed order.
- `in_ready`  out  1  block can accept a word this cycle.
- `out_valid`  out  1  `out_data` holds a reordered coefficient.
- `out_data`  out  data_width  coefficient, natural order.
- `out_ready`  in  1  consumer accepts a word this cycle.
- `out_last`  out  1  high with `out_valid` on the n-th word of a frame.
- `frame_done_tick`  out  1  one-cycle pulse registered after the last-word output handshake.

## Operation
- Storage: two banks (0, 1) of n words each, built from flops. Each bank has a 1-bit `full` flag.
- Write side: pointer `wr_sel` and counter `wr_cnt` (addr_width bits).
  - `in_ready` = !full[wr_sel].
  - On `in_valid && in_ready`: bank[wr_sel][wr_cnt] <= in_data, and `wr_cnt` increments.
  - When `wr_cnt` = n-1 is accepted: `wr_cnt` wraps to 0, full[wr_sel] <= 1, and `wr_sel` toggles.
- Read side: pointer `rd_sel` and counter `rd_cnt`.
  - `out_valid` = full[rd_sel].
  - `out_data` = bank[rd_sel][bitrev(rd_cnt)], a combinational mux from the storage flops.
  - `out_last` = out_valid && rd_cnt = n-1.
  - On `out_valid && out_ready`: `rd_cnt` increments.
  - On the last word: `rd_cnt` wraps to 0, full[rd_sel] <= 0, `rd_sel` toggles, and `frame_done_tick` <= 1 for one cycle.
- bitrev(a) reverses the addr_width bits of a. Bit reversal is its own inverse, so input position j maps to output position bitrev(j).
- Per-bank state sequence: EMPTY → FILLING (`wr_sel` points at it, `wr_cnt` > 0) → FULL → DRAINING (`rd_sel` points at it, `rd_cnt` > 0) → EMPTY.
- Simultaneous events:
  - Final write to one bank and final read from the other in the same cycle: both flag updates apply.
  - Because `in_ready` and `out_valid` depend on registered flags, there is no combinational path from input to output handshakes.
- Reset: flags, counters, pointers and `frame_done_tick` return to 0. Storage contents are not cleared.
  - An in-progress frame is discarded. After reset release the first accepted word is treated as index 0.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_last`=0, `frame_done_tick`=0. `out_data` is don't-care while `out_valid`=0.
- Latency: `out_valid` rises the cycle after the n-th input handshake of a frame.
  - With `out_ready` held high, the frame drains in n consecutive cycles.
- Both banks full: `in_ready`=0 until the cycle after the draining bank's last read handshake.
- `out_ready` low stalls `rd_cnt`. `out_data` and `out_last` stay stable while stalled.
- `in_valid` without `in_ready`: no state change. Upstream must hold its data.

## Configuration
- `BITREV_REORDER_EN` defined: read address = bitrev(rd_cnt), which is the normal NTT mode.
- Not defined: read address = rd_cnt. The block becomes a two-frame ping-pong FIFO with identical handshakes and latency, for pipelines whose upstream already emits natural order.

## Test plan
- n=8, macro defined, input 0x10..0x17 back-to-back, `out_ready`=1 → output 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17. `out_valid` rises the cycle after 0x17 is accepted, `out_last` is set on 0x17, `frame_done_tick` pulses the next cycle.
- Three frames streamed continuously with `out_ready`=1 → `in_ready` never drops and outputs are contiguous after the first frame's fill.
- `out_ready`=0, two frames offered → 16 words accepted, then `in_ready`=0. Raising `out_ready` drains frame 0 first, and `in_ready` returns the cycle after frame 0's last read.
- `out_ready` toggling 1,0,1,0 mid-frame → no lost or duplicated words, and `out_data` is stable during stalls.
- `rst_n` pulsed low after 5 words of a frame, then input 0x20..0x27 → output 0x20,0x24,0x22,0x26,0x21,0x25,0x23,0x27, with no stale words.
- Macro undefined, input 0x10..0x17 → output 0x10..0x17 in order, with the same cycle timing as scenario 1.
